// File: rtl/program_loader.sv
// program_loader: writer side of the instruction memory.
// Assembles a little-endian byte stream into 32-bit words, writes them to
// word addresses 0, 1, 2, ... and holds the CPU halted until a complete
// program terminated by HALT_WORD has been written.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing XOR checksum byte).
module program_loader #(
   parameter int          DEPTH     = 64,
   parameter int          ADDR_W    = 6,
   parameter logic [31:0] HALT_WORD = 32'h0000007F
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              cpu_hlt,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   word_count
);

   localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

`ifdef LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DONE, S_ERR, S_CSUM} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_t;
`endif

   state_t            state_reg;
   state_t            state_next;
   logic [1:0]        byte_idx_reg;
   logic              wr_en_reg;
   logic [ADDR_W-1:0] wr_addr_reg;
   logic [31:0]       wr_data_reg;
   logic [ADDR_W:0]   word_count_reg;
   logic [31:0]       word_next;
   logic              load_byte;
   logic              word_done;
   logic              start_ok;
   logic              halt_write;
   logic              last_write;

   // A byte is only consumed while loading; byte_ready is 1 throughout LOAD.
   assign load_byte  = byte_valid && (state_reg == S_LOAD);
   assign word_done  = load_byte && (byte_idx_reg == 2'd3);
   assign start_ok   = start && (state_reg == S_IDLE || state_reg == S_DONE ||
                                 state_reg == S_ERR);
   // Terminating conditions are evaluated in the write cycle itself, so the
   // state changes on the same edge the memory captures the word.
   assign halt_write = wr_en_reg && (wr_data_reg == HALT_WORD);
   assign last_write = wr_en_reg && (wr_addr_reg == LAST_ADDR);

   // Byte lanes 0..2 of the word under assembly; lane 3 is taken straight
   // from the bus when the 4th byte arrives.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_lane
         logic [7:0] lane_reg;
         // Capture the byte that belongs to this lane.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               lane_reg <= '0;
            end else if (load_byte && byte_idx_reg == 2'(gi)) begin
               lane_reg <= byte_data;
            end
         end
      end
   endgenerate

   assign word_next = {byte_data, g_lane[2].lane_reg, g_lane[1].lane_reg,
                       g_lane[0].lane_reg};

`ifdef LOADER_CHECKSUM_EN
   logic [7:0] csum_reg;
   logic       csum_match;

   assign csum_match = (byte_data == csum_reg);

   // Running XOR of every program byte accepted in this load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         csum_reg <= '0;
      end else if (start_ok) begin
         csum_reg <= '0;
      end else if (load_byte) begin
         csum_reg <= csum_reg ^ byte_data;
      end
   end
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state and state-decoded outputs.
   always_comb begin
      state_next = state_reg;
      byte_ready = 1'b0;
      cpu_hlt    = 1'b1;
      done       = 1'b0;
      err        = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (start) state_next = S_LOAD;
         end
         S_LOAD: begin
            byte_ready = 1'b1;
            if (halt_write) begin
`ifdef LOADER_CHECKSUM_EN
               // A byte arriving in the HALT write cycle is the checksum.
               if (byte_valid) state_next = csum_match ? S_DONE : S_ERR;
               else            state_next = S_CSUM;
`else
               state_next = S_DONE;
`endif
            end else if (last_write) begin
               state_next = S_ERR;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            cpu_hlt = 1'b0;
            if (start) state_next = S_LOAD;
         end
         S_ERR: begin
            err = 1'b1;
            if (start) state_next = S_LOAD;
         end
`ifdef LOADER_CHECKSUM_EN
         S_CSUM: begin
            byte_ready = 1'b1;
            if (byte_valid) state_next = csum_match ? S_DONE : S_ERR;
         end
`endif
         default: state_next = S_IDLE;
      endcase
   end

   // Byte index, write port registers and word counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_idx_reg   <= '0;
         wr_en_reg      <= 1'b0;
         wr_addr_reg    <= '0;
         wr_data_reg    <= '0;
         word_count_reg <= '0;
      end else begin
         // Only a 4th byte in LOAD launches a write, so the strobe can
         // never appear outside the LOAD write cycle.
         wr_en_reg <= word_done;
         if (start_ok) begin
            byte_idx_reg   <= '0;
            wr_addr_reg    <= '0;
            word_count_reg <= '0;
         end else begin
            if (load_byte) begin
               byte_idx_reg <= byte_idx_reg + 2'd1;
            end
            if (word_done) begin
               wr_addr_reg <= word_count_reg[ADDR_W-1:0];
               wr_data_reg <= word_next;
               if (word_count_reg != DEPTH_CNT) begin
                  word_count_reg <= word_count_reg + CNT_ONE;
               end
            end
         end
      end
   end

   assign wr_en      = wr_en_reg;
   assign wr_addr    = wr_addr_reg;
   assign wr_data    = wr_data_reg;
   assign word_count = word_count_reg;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: self-checking bench for program_loader.
// Table-driven program runs with random words and byte gaps, checked against
// a word-level reference model, plus hand-written corner-case sequences.
// Honours LOADER_CHECKSUM_EN by appending the XOR checksum byte.
module tb_program_loader;

   localparam int          DEPTH  = 64;
   localparam int          ADDR_W = 6;
   localparam logic [31:0] HALT   = 32'h0000007F;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              byte_valid = 1'b0;
   logic [7:0]        byte_data = 8'h00;
   logic              byte_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic              cpu_hlt;
   logic              done;
   logic              err;
   logic [ADDR_W:0]   word_count;

   program_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .HALT_WORD(HALT)) dut (
      .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
      .byte_data(byte_data), .byte_ready(byte_ready), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data), .cpu_hlt(cpu_hlt), .done(done),
      .err(err), .word_count(word_count)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [7:0]  xor_acc  = 8'h00;
   logic [31:0] prog[$];
   int          got_addr[$];
   logic [31:0] got_data[$];

   typedef struct {
      int nwords;
      bit halt_last;
      int max_gap;
      bit exp_done;
      bit exp_err;
      int exp_count;
   } vec_t;
   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      w = $urandom;
      if (w == HALT) w = w ^ 32'h100;
      return w;
   endfunction

   // Scoreboard: record every memory write.
   always @(negedge clk) begin
      if (wr_en) begin
         got_addr.push_back(int'(wr_addr));
         got_data.push_back(wr_data);
         $display("write addr=%0d data=%08h", wr_addr, wr_data);
         check("wr_en_outside_load", {30'd0, done, err}, 32'd0);
      end
   end

   // Drive one byte (called at a negedge) and return at the negedge after
   // the edge that transferred it.
   task automatic send_byte(input logic [7:0] b, input int max_gap);
      int n;
      if (max_gap > 0) begin
         byte_valid = 1'b0;
         repeat ($urandom_range(max_gap)) @(negedge clk);
      end
      byte_valid = 1'b1;
      byte_data  = b;
      n = 0;
      while (!byte_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!byte_ready) begin
         check("byte_ready_timeout", {31'd0, byte_ready}, 32'd1);
         byte_valid = 1'b0;
      end else begin
         xor_acc = xor_acc ^ b;
         @(negedge clk);
      end
   endtask

   task automatic send_word(input logic [31:0] w, input int max_gap);
      for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], max_gap);
   endtask

   task automatic pulse_start();
      got_addr.delete();
      got_data.delete();
      xor_acc = 8'h00;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Load prog[] and compare against the word-level model: words land at
   // consecutive addresses until HALT (success) or until DEPTH words (error).
   task automatic run_program(input int max_gap);
      int n_exp;
      bit m_done;
      bit m_err;
      pulse_start();
      foreach (prog[i]) send_word(prog[i], max_gap);
      byte_valid = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      if (prog[prog.size()-1] == HALT) begin
         send_byte(xor_acc, max_gap);
         byte_valid = 1'b0;
      end
`endif
      repeat (3) @(negedge clk);
      n_exp = 0; m_done = 1'b0; m_err = 1'b0;
      for (int i = 0; i < prog.size(); i++) begin
         n_exp++;
         if (prog[i] == HALT) begin m_done = 1'b1; break; end
         if (i == DEPTH - 1) begin m_err = 1'b1; break; end
      end
      check("n_writes", got_addr.size(), n_exp);
      for (int i = 0; i < n_exp && i < got_addr.size(); i++) begin
         check($sformatf("wr_addr[%0d]", i), got_addr[i], i);
         check($sformatf("wr_data[%0d]", i), got_data[i], prog[i]);
      end
      check("model_done", {31'd0, done}, {31'd0, m_done});
      check("model_err", {31'd0, err}, {31'd0, m_err});
      check("model_cpu_hlt", {31'd0, cpu_hlt}, {31'd0, !m_done});
      check("model_byte_ready", {31'd0, byte_ready}, 32'd0);
      check("model_word_count", word_count, n_exp);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  t1[8];
      logic [31:0] fact[19];
      int          n_before;

      vecs[0] = '{1,  1'b1, 0, 1'b1, 1'b0, 1};
      vecs[1] = '{2,  1'b1, 0, 1'b1, 1'b0, 2};
      vecs[2] = '{5,  1'b1, 2, 1'b1, 1'b0, 5};
      vecs[3] = '{20, 1'b1, 3, 1'b1, 1'b0, 20};
      vecs[4] = '{64, 1'b1, 0, 1'b1, 1'b0, 64};
      vecs[5] = '{64, 1'b0, 0, 1'b0, 1'b1, 64};
      vecs[6] = '{64, 1'b0, 2, 1'b0, 1'b1, 64};

      t1 = '{8'h13, 8'h05, 8'h60, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h00};
      fact = '{32'h00500513, 32'h00100593, 32'h00058613, 32'h00060693,
               32'hfff50513, 32'h02b585b3, 32'hfe051ce3, 32'h00b02023,
               32'h00002283, 32'h00128293, 32'h00502223, 32'h00402303,
               32'h00030393, 32'h00638433, 32'h00800493, 32'h00949513,
               32'h00a02423, 32'h00802583, 32'h00000013};

      // Reset state.
      repeat (2) @(negedge clk);
      check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
      check("rst_wr_en", {31'd0, wr_en}, 32'd0);
      check("rst_cpu_hlt", {31'd0, cpu_hlt}, 32'd1);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_word_count", word_count, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_byte_ready", {31'd0, byte_ready}, 32'd0);

      // Two-word program at 1 byte/clk with latency checks.
      pulse_start();
      for (int i = 0; i < 4; i++) send_byte(t1[i], 0);
      check("t1_w0_en", {31'd0, wr_en}, 32'd1);
      check("t1_w0_addr", wr_addr, 32'd0);
      check("t1_w0_data", wr_data, 32'h00600513);
      check("t1_w0_ready", {31'd0, byte_ready}, 32'd1);
      for (int i = 4; i < 8; i++) send_byte(t1[i], 0);
      byte_valid = 1'b0;
      check("t1_w1_en", {31'd0, wr_en}, 32'd1);
      check("t1_w1_addr", wr_addr, 32'd1);
      check("t1_w1_data", wr_data, 32'h0000007F);
`ifdef LOADER_CHECKSUM_EN
      send_byte(xor_acc, 0);
      byte_valid = 1'b0;
`else
      @(negedge clk);
`endif
      check("t1_done", {31'd0, done}, 32'd1);
      check("t1_cpu_hlt", {31'd0, cpu_hlt}, 32'd0);
      check("t1_byte_ready", {31'd0, byte_ready}, 32'd0);
      check("t1_word_count", word_count, 32'd2);
      check("t1_n_writes", got_addr.size(), 32'd2);

      // From DONE: restart with a HALT-only program, start pulses mid-load.
      start = 1'b1;
      check("rs_hlt_before", {31'd0, cpu_hlt}, 32'd0);
      got_addr.delete(); got_data.delete(); xor_acc = 8'h00;
      @(negedge clk);
      start = 1'b0;
      check("rs_hlt_after", {31'd0, cpu_hlt}, 32'd1);
      check("rs_done_clr", {31'd0, done}, 32'd0);
      check("rs_word_count_clr", word_count, 32'd0);
      send_byte(8'h7F, 0);
      byte_valid = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      byte_valid = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      send_byte(8'h00, 0);
      byte_valid = 1'b0;
      check("rs_wr_en", {31'd0, wr_en}, 32'd1);
      check("rs_wr_addr", wr_addr, 32'd0);
      check("rs_wr_data", wr_data, HALT);
      check("rs_hlt_write_cycle", {31'd0, cpu_hlt}, 32'd1);
`ifdef LOADER_CHECKSUM_EN
      send_byte(xor_acc, 0);
      byte_valid = 1'b0;
`else
      @(negedge clk);
`endif
      check("rs_hlt_released", {31'd0, cpu_hlt}, 32'd0);
      check("rs_done", {31'd0, done}, 32'd1);
      check("rs_word_count", word_count, 32'd1);

      // Factorial program with random gaps.
      prog.delete();
      foreach (fact[i]) prog.push_back(fact[i]);
      prog.push_back(HALT);
      run_program(3);

      // Table-driven programs.
      for (int k = 0; k < 7; k++) begin
         prog.delete();
         for (int i = 0; i < vecs[k].nwords - 1; i++) prog.push_back(rand_word());
         prog.push_back(vecs[k].halt_last ? HALT : rand_word());
         run_program(vecs[k].max_gap);
         check($sformatf("tbl%0d_done", k), {31'd0, done}, {31'd0, vecs[k].exp_done});
         check($sformatf("tbl%0d_err", k), {31'd0, err}, {31'd0, vecs[k].exp_err});
         check($sformatf("tbl%0d_count", k), word_count, vecs[k].exp_count);
         if (vecs[k].exp_err) begin
            n_before = got_addr.size();
            byte_valid = 1'b1;
            repeat (8) begin
               byte_data = 8'($urandom);
               @(negedge clk);
            end
            byte_valid = 1'b0;
            check($sformatf("tbl%0d_no_extra_write", k), got_addr.size(), n_before);
            check($sformatf("tbl%0d_err_hlt", k), {31'd0, cpu_hlt}, 32'd1);
         end
      end

      // Reset after 2 bytes of word 3, then a clean reload.
      pulse_start();
      for (int i = 0; i < 3; i++) send_word(rand_word(), 0);
      send_byte(8'hA5, 0);
      send_byte(8'h5A, 0);
      byte_valid = 1'b0;
      check("pre_rst_addr", wr_addr, 32'd2);
      #2 rst = 1'b1;
      #1;
      check("arst_byte_ready", {31'd0, byte_ready}, 32'd0);
      check("arst_wr_en", {31'd0, wr_en}, 32'd0);
      check("arst_wr_addr", wr_addr, 32'd0);
      check("arst_wr_data", wr_data, 32'd0);
      check("arst_cpu_hlt", {31'd0, cpu_hlt}, 32'd1);
      check("arst_done", {31'd0, done}, 32'd0);
      check("arst_err", {31'd0, err}, 32'd0);
      check("arst_word_count", word_count, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      prog.delete();
      prog.push_back(rand_word());
      prog.push_back(rand_word());
      prog.push_back(HALT);
      run_program(1);

      // Fully random programs against the model.
      for (int r = 0; r < 6; r++) begin
         int len;
         len = $urandom_range(64, 1);
         prog.delete();
         for (int i = 0; i < len - 1; i++) prog.push_back(rand_word());
         if (len == DEPTH && $urandom_range(1)) prog.push_back(rand_word());
         else prog.push_back(HALT);
         run_program($urandom_range(3));
      end

`ifdef LOADER_CHECKSUM_EN
      // Checksum match and mismatch on a HALT-only program.
      pulse_start();
      send_word(HALT, 0);
      send_byte(8'h7F, 0);
      byte_valid = 1'b0;
      @(negedge clk);
      check("csum_ok_done", {31'd0, done}, 32'd1);
      check("csum_ok_hlt", {31'd0, cpu_hlt}, 32'd0);
      pulse_start();
      send_word(HALT, 0);
      byte_valid = 1'b0;
      @(negedge clk);
      check("csum_wait_hlt", {31'd0, cpu_hlt}, 32'd1);
      send_byte(8'h00, 0);
      byte_valid = 1'b0;
      @(negedge clk);
      check("csum_bad_err", {31'd0, err}, 32'd1);
      check("csum_bad_hlt", {31'd0, cpu_hlt}, 32'd1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
